// File: rtl/if_fetch_icache_pkg.sv
// Shared constants and types for the instruction-fetch unit and its cache.
package if_fetch_icache_pkg;

  localparam int unsigned ICACHE_ENTRIES_DEF = 128;
  localparam int unsigned ADDR_W_DEF         = 32;
  localparam int unsigned INST_W             = 32;

  typedef logic [INST_W-1:0] reg_bus_t;

  // IDLE: lookup, FETCH: miss outstanding at mem_ctrl, DROP: one-cycle request gap
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage.
// Combinational read by index, single synchronous write port.
module if_fetch_icache_array #(
  parameter int unsigned ENTRIES = 128,
  parameter int unsigned IDX_W   = 7,
  parameter int unsigned TAG_W   = 23,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];

  // only the valid bits need a reset; tag/data are qualified by them
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/if_fetch_icache.sv
// Instruction-fetch initiator: PC register, direct-mapped icache lookup,
// miss requests to mem_ctrl, stall hold and branch redirect.
module if_fetch_icache
  import if_fetch_icache_pkg::*;
#(
  parameter int unsigned ICACHE_ENTRIES = ICACHE_ENTRIES_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              stall_in,
  input  logic              br_flag_in,
  input  logic [ADDR_W-1:0] br_target_in,
  output logic              if_req_out,
  output logic [ADDR_W-1:0] inst_addr_out,
  input  logic              inst_done_in,
  input  logic [INST_W-1:0] inst_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid_out
);

  localparam int unsigned IDX_W = $clog2(ICACHE_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  fetch_state_t      state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              if_req_n;
  logic [ADDR_W-1:0] inst_addr_n;
  logic [ADDR_W-1:0] pc_out_n;
  reg_bus_t          inst_out_n;
  logic              inst_valid_n;

  logic              cache_we_c;
  logic              rd_valid_c;
  logic [TAG_W-1:0]  rd_tag_c;
  reg_bus_t          rd_data_c;
  logic              hit_c;
  logic              br_lsb_unused_c;

  assign br_lsb_unused_c = |br_target_in[1:0];

  if_fetch_icache_array #(
    .ENTRIES (ICACHE_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (INST_W)
  ) u_icache_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .we       (cache_we_c),
    .wr_idx   (inst_addr_out[IDX_W+1:2]),
    .wr_tag   (inst_addr_out[ADDR_W-1:IDX_W+2]),
    .wr_data  (inst_in),
    .rd_idx   (pc_q[IDX_W+1:2]),
    .rd_valid (rd_valid_c),
    .rd_tag   (rd_tag_c),
    .rd_data  (rd_data_c)
  );

  assign hit_c = rd_valid_c && (rd_tag_c == pc_q[ADDR_W-1:IDX_W+2]);

  // next-state, next-PC and next-output logic
  always_comb begin
    state_n      = state_q;
    pc_n         = pc_q;
    if_req_n     = if_req_out;
    inst_addr_n  = inst_addr_out;
    pc_out_n     = pc_out;
    inst_out_n   = inst_out;
    inst_valid_n = stall_in ? inst_valid_out : 1'b0;
    cache_we_c   = 1'b0;

    if (br_flag_in) begin
      // redirect wins; a word landing now is still cached but never presented
      pc_n         = {br_target_in[ADDR_W-1:2], 2'b00};
      inst_valid_n = 1'b0;
      if_req_n     = 1'b0;
      cache_we_c   = (state_q == ST_FETCH) && inst_done_in;
      state_n      = (state_q == ST_FETCH) ? ST_DROP : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stall_in) begin
            if (hit_c) begin
              pc_out_n     = pc_q;
              inst_out_n   = rd_data_c;
              inst_valid_n = 1'b1;
              pc_n         = pc_q + ADDR_W'(4);
            end else begin
              state_n     = ST_FETCH;
              if_req_n    = 1'b1;
              inst_addr_n = pc_q;
            end
          end
        end
        ST_FETCH: begin
          if (inst_done_in) begin
            cache_we_c = 1'b1;
            if_req_n   = 1'b0;
            state_n    = ST_IDLE;
            if (!stall_in) begin
              pc_out_n     = pc_q;
              inst_out_n   = inst_in;
              inst_valid_n = 1'b1;
              pc_n         = pc_q + ADDR_W'(4);
            end
          end
        end
        ST_DROP: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end

    if (!rdy_in) cache_we_c = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      if_req_out     <= 1'b0;
      inst_addr_out  <= '0;
      pc_out         <= '0;
      inst_out       <= '0;
      inst_valid_out <= 1'b0;
    end else if (rdy_in) begin
      state_q        <= state_n;
      pc_q           <= pc_n;
      if_req_out     <= if_req_n;
      inst_addr_out  <= inst_addr_n;
      pc_out         <= pc_out_n;
      inst_out       <= inst_out_n;
      inst_valid_out <= inst_valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_icache.sv
// Randomized bench for if_fetch_icache with an address-map cache model and a
// latency-driven mem_ctrl responder.
module tb_if_fetch_icache;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        br_flag_in;
  logic [31:0] br_target_in;
  logic        if_req_out;
  logic [31:0] inst_addr_out;
  logic        inst_done_in;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid_out;

  if_fetch_icache dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .stall_in       (stall_in),
    .br_flag_in     (br_flag_in),
    .br_target_in   (br_target_in),
    .if_req_out     (if_req_out),
    .inst_addr_out  (inst_addr_out),
    .inst_done_in   (inst_done_in),
    .inst_in        (inst_in),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .inst_valid_out (inst_valid_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // reference model: expected outputs, PC and a map of which address each line holds
  logic [31:0] m_pc, m_pc_out, m_inst, m_addr;
  bit          m_valid, m_req, m_wait, m_gap;
  bit          c_v [128];
  logic [31:0] c_a [128];
  logic [31:0] c_d [128];

  int unsigned mem_cnt = 0;
  int unsigned mem_lat = 5;
  bit          rand_lat = 1'b0;
  bit          spur_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h8) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_pc_out = '0; m_inst = '0; m_addr = '0;
    m_valid = 1'b0; m_req = 1'b0; m_wait = 1'b0; m_gap = 1'b0;
    for (int i = 0; i < 128; i++) c_v[i] = 1'b0;
    mem_cnt = 0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] w);
    int unsigned idx;
    idx = (a >> 2) % 128;
    c_v[idx] = 1'b1; c_a[idx] = a; c_d[idx] = w;
  endtask

  task automatic present(input logic [31:0] w);
    m_pc_out = m_pc; m_inst = w; m_valid = 1'b1; m_pc = m_pc + 32'd4;
  endtask

  task automatic check_outputs();
    chk("if_req", 32'(if_req_out), 32'(m_req));
    chk("inst_addr", inst_addr_out, m_addr);
    chk("inst_valid", 32'(inst_valid_out), 32'(m_valid));
    chk("pc_out", pc_out, m_pc_out);
    chk("inst_out", inst_out, m_inst);
  endtask

  // one clock: mem responder, drive inputs, advance model, check after the edge
  task automatic step(input bit stall, input bit br, input logic [31:0] tgt, input bit rdy);
    bit          done;
    logic [31:0] word;
    int unsigned idx;
    done = 1'b0;
    word = $urandom;
    if (m_req && rdy) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        done = 1'b1; word = mem_word(m_addr); mem_cnt = 0;
        mem_lat = rand_lat ? $urandom_range(1, 6) : 5;
      end
    end else if (!m_req) begin
      mem_cnt = 0;
    end
    if (!done && (!m_req || !rdy) && spur_en && ($urandom_range(0, 9) == 0)) done = 1'b1;

    stall_in = stall; br_flag_in = br; br_target_in = tgt; rdy_in = rdy;
    inst_done_in = done; inst_in = word;

    if (rdy) begin
      if (br) begin
        if (m_wait && done) fill(m_addr, word);
        m_gap = m_wait; m_wait = 1'b0; m_req = 1'b0;
        m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0;
      end else if (m_gap) begin
        m_gap = 1'b0;
        if (!stall) m_valid = 1'b0;
      end else if (m_wait) begin
        if (done) begin
          fill(m_addr, word); m_wait = 1'b0; m_req = 1'b0;
          if (!stall) present(word);
        end else if (!stall) begin
          m_valid = 1'b0;
        end
      end else if (!stall) begin
        idx = (m_pc >> 2) % 128;
        if (c_v[idx] && c_a[idx] == m_pc) present(c_d[idx]);
        else begin
          m_wait = 1'b1; m_req = 1'b1; m_addr = m_pc; m_valid = 1'b0;
        end
      end
    end

    @(posedge clk_in);
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    step(1'b0, 1'b1, tgt, 1'b1);
  endtask

  task automatic run_until_req();
    int n = 0;
    while (!m_req && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("wait_req", 32'(if_req_out), 32'd1);
  endtask

  // asynchronous reset asserted between edges, released on a falling edge
  task automatic do_reset();
    inst_done_in = 1'b0; br_flag_in = 1'b0; stall_in = 1'b0; rdy_in = 1'b1;
    #2 rst_in = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk_in);
    check_outputs();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; stall_in = 1'b0; br_flag_in = 1'b0;
    br_target_in = '0; inst_done_in = 1'b0; inst_in = '0;
    model_reset();
    @(negedge clk_in);
    check_outputs();
    rst_in = 1'b0;

    // cold start: 0x0 and 0x4 miss, then a warm loop 0x0/0x4 runs from the cache
    idle_steps(16);
    redirect(32'h0);
    idle_steps(2);
    redirect(32'h0);
    idle_steps(2);
    redirect(32'h0);
    idle_steps(2);

    // redirect while 0x8 is outstanding
    redirect(32'h8);
    run_until_req();
    idle_steps(2);
    redirect(32'h100);
    idle_steps(3);
    chk("redir_addr", inst_addr_out, 32'h100);
    idle_steps(6);

    // miss completes under stall, then presented from the cache
    redirect(32'h8);
    run_until_req();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    idle_steps(3);

    // aliasing lines 0x0 / 0x200
    redirect(32'h0);
    idle_steps(3);
    redirect(32'h200);
    idle_steps(8);
    redirect(32'h0);
    idle_steps(8);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFF8);
    idle_steps(16);

    // reset mid-fetch: cache is cold afterwards
    redirect(32'h44);
    run_until_req();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset();
    run_until_req();
    chk("req_after_reset", inst_addr_out, 32'h0);
    idle_steps(10);

    // randomized traffic
    rand_lat = 1'b1;
    spur_en  = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit          st, br, rd;
      logic [31:0] tgt;
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 11) == 0);
      rd = ($urandom_range(0, 7) != 0);
      tgt = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 32'h7FF));
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(st, br, tgt, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
